// File: rtl/map_scan_mux.sv
// Selects one of NMAPS pixel maps, latches it once per frame into a tear-free
// buffer and row-scans it onto an LED matrix with an optional blinking cursor.
module map_scan_mux #(
   parameter  int COLS         = 5,
   parameter  int ROWS         = 7,
   parameter  int NMAPS        = 2,
   parameter  int ROW_DIV      = 1000,
   parameter  int BLINK_FRAMES = 25,
   localparam int SELW         = (NMAPS > 1) ? $clog2(NMAPS) : 1,
   localparam int CCW          = (COLS > 1) ? $clog2(COLS) : 1,
   localparam int RIW          = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NMAPS*COLS*ROWS-1:0]  maps_in,
   input  logic [SELW-1:0]             map_sel,
   input  logic                        cursor_en,
   input  logic [CCW-1:0]              cursor_col,
   input  logic [RIW-1:0]              cursor_row,
   input  logic                        blink_en,
   output logic [ROWS-1:0]             row_out,
   output logic [COLS-1:0]             col_out,
   output logic                        frame_start,
   output logic [SELW-1:0]             active_map
);

   localparam int PIX  = COLS * ROWS;
   localparam int DIVW = $clog2(ROW_DIV);
   localparam int BCW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [DIVW-1:0] div_q, div_d;
   logic [RIW-1:0]  next_row_q, next_row_d;
   logic [BCW-1:0]  blink_cnt_q, blink_cnt_d;
   logic            blink_phase_q, blink_phase_d;
   logic [SELW-1:0] active_map_q, active_map_d;
   logic [PIX-1:0]  fbuf_q, fbuf_d;
   logic [ROWS-1:0] row_out_q, row_out_d;
   logic [COLS-1:0] col_out_q, col_out_d;
   logic            frame_start_q, frame_start_d;
   logic [COLS-1:0] row_bits;
   logic            tick;

   assign tick = (div_q == DIVW'(ROW_DIV - 1));

   always_comb begin
      div_d         = div_q + 1'b1;
      next_row_d    = next_row_q;
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
      active_map_d  = active_map_q;
      fbuf_d        = fbuf_q;
      row_out_d     = row_out_q;
      col_out_d     = col_out_q;
      frame_start_d = 1'b0;
      row_bits      = '0;
      if (tick) begin
         div_d = '0;
         // Frame start: an out-of-range select keeps the previous map.
         if (next_row_q == '0) begin
            if ({1'b0, map_sel} < (SELW + 1)'(NMAPS)) active_map_d = map_sel;
            for (int m = 0; m < NMAPS; m++) begin
               if (active_map_d == SELW'(m)) fbuf_d = maps_in[m*PIX +: PIX];
            end
            frame_start_d = 1'b1;
            if (blink_cnt_q == BCW'(BLINK_FRAMES - 1)) begin
               blink_cnt_d   = '0;
               blink_phase_d = ~blink_phase_q;
            end else begin
               blink_cnt_d = blink_cnt_q + 1'b1;
            end
         end
         for (int r = 0; r < ROWS; r++) begin
            row_out_d[r] = (next_row_q == RIW'(r));
            if (next_row_q == RIW'(r)) row_bits = fbuf_d[r*COLS +: COLS];
         end
         // Cursor uses the post-toggle phase so row 0 of a new frame is consistent.
         if (cursor_en && (cursor_row == next_row_q)) begin
            for (int c = 0; c < COLS; c++) begin
               if (cursor_col == CCW'(c)) row_bits[c] = blink_en ? blink_phase_d : 1'b1;
            end
         end
         col_out_d  = row_bits;
         next_row_d = (next_row_q == RIW'(ROWS - 1)) ? '0 : next_row_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q         <= '0;
         next_row_q    <= '0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b1;
         active_map_q  <= '0;
         fbuf_q        <= '0;
         row_out_q     <= '0;
         col_out_q     <= '0;
         frame_start_q <= 1'b0;
      end else begin
         div_q         <= div_d;
         next_row_q    <= next_row_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         active_map_q  <= active_map_d;
         fbuf_q        <= fbuf_d;
         row_out_q     <= row_out_d;
         col_out_q     <= col_out_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign row_out     = row_out_q;
   assign col_out     = col_out_q;
   assign frame_start = frame_start_q;
   assign active_map  = active_map_q;

endmodule

// File: tb/tb_map_scan_mux.sv
// Bench for map_scan_mux: a two-map and a three-map instance share stimulus and
// are checked every cycle against a frame/row arithmetic model plus literal points.
module tb_map_scan_mux;
   localparam int COLS = 5;
   localparam int ROWS = 7;
   localparam int RD   = 4;
   localparam int BF   = 2;
   localparam int PIX  = COLS * ROWS;

   logic             clk = 1'b0;
   logic             rst;
   logic [3*PIX-1:0] maps3;
   logic [2*PIX-1:0] maps2;
   logic [1:0]       sel3;
   logic             sel2;
   logic             cen, ben;
   logic [2:0]       ccol, crow;
   logic [6:0]       row2, row3;
   logic [4:0]       col2, col3;
   logic             fs2, fs3;
   logic             act2;
   logic [1:0]       act3;

   int errors = 0;
   int checks = 0;
   int j      = 0;

   assign maps2 = maps3[2*PIX-1:0];
   assign sel2  = sel3[0];

   always #5 clk = ~clk;

   map_scan_mux #(.COLS(COLS), .ROWS(ROWS), .NMAPS(2), .ROW_DIV(RD), .BLINK_FRAMES(BF)) dut2 (
      .clk(clk), .rst(rst), .maps_in(maps2), .map_sel(sel2), .cursor_en(cen),
      .cursor_col(ccol), .cursor_row(crow), .blink_en(ben), .row_out(row2),
      .col_out(col2), .frame_start(fs2), .active_map(act2));

   map_scan_mux #(.COLS(COLS), .ROWS(ROWS), .NMAPS(3), .ROW_DIV(RD), .BLINK_FRAMES(BF)) dut3 (
      .clk(clk), .rst(rst), .maps_in(maps3), .map_sel(sel3), .cursor_en(cen),
      .cursor_col(ccol), .cursor_row(crow), .blink_en(ben), .row_out(row3),
      .col_out(col3), .frame_start(fs3), .active_map(act3));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Model: outputs follow from the count of clock edges since reset.
   int             n;
   int             exp_act [2];
   logic [6:0]     exp_row [2];
   logic [4:0]     exp_col [2];
   logic           exp_fs  [2];
   logic [PIX-1:0] mbuf    [2];

   always @(posedge clk) begin
      int k, row, f, s, nm;
      logic ph;
      logic [4:0] c;
      if (rst) begin
         n = 0;
         for (int i = 0; i < 2; i++) begin
            exp_act[i] = 0; exp_row[i] = '0; exp_col[i] = '0; exp_fs[i] = 1'b0; mbuf[i] = '0;
         end
      end else begin
         n++;
         for (int i = 0; i < 2; i++) exp_fs[i] = 1'b0;
         if (n % RD == 0) begin
            k   = n / RD - 1;
            row = k % ROWS;
            f   = k / ROWS;
            ph  = (((f + 1) / BF) % 2) == 0;
            for (int i = 0; i < 2; i++) begin
               if (row == 0) begin
                  s  = (i == 0) ? int'(sel2) : int'(sel3);
                  nm = (i == 0) ? 2 : 3;
                  if (s < nm) exp_act[i] = s;
                  mbuf[i]   = maps3[exp_act[i]*PIX +: PIX];
                  exp_fs[i] = 1'b1;
               end
               exp_row[i] = 7'(1 << row);
               c = mbuf[i][row*COLS +: COLS];
               if (cen && int'(crow) == row && int'(ccol) < COLS) c[ccol] = ben ? ph : 1'b1;
               exp_col[i] = c;
            end
         end
      end
      #1;
      chk("row_out2", row2, exp_row[0]);
      chk("col_out2", col2, exp_col[0]);
      chk("frame_start2", fs2, exp_fs[0]);
      chk("active_map2", act2, exp_act[0]);
      chk("row_out3", row3, exp_row[1]);
      chk("col_out3", col3, exp_col[1]);
      chk("frame_start3", fs3, exp_fs[1]);
      chk("active_map3", act3, exp_act[1]);
   end

   task automatic step();
      @(negedge clk);
      j++;
   endtask

   task automatic goto(input int t);
      while (j < t) step();
   endtask

   initial begin
      rst = 1'b1; cen = 1'b0; ben = 1'b1; ccol = '0; crow = '0; sel3 = 2'd1;
      maps3 = '0;
      for (int r = 0; r < ROWS; r++) maps3[r*COLS +: COLS] = 5'b00001 << (r % 5);
      maps3[PIX +: PIX]   = '1;
      maps3[2*PIX +: PIX] = {7{5'b01010}};
      repeat (3) @(negedge clk);
      rst = 1'b0; j = 0;

      repeat (3) begin
         step();
         chk("blank_row", row2, 7'b0);
         chk("blank_col", col2, 5'b0);
      end
      step();
      chk("first_row", row2, 7'b0000001);
      chk("first_fs", fs2, 1'b1);
      chk("first_col", col2, 5'b11111);
      chk("first_act", act2, 1'b1);
      step();
      chk("fs_one_cycle", fs2, 1'b0);
      goto(8);  chk("row1", row2, 7'b0000010);
      goto(10); sel3 = 2'd0;
      goto(28); chk("row6_f0", row2, 7'b1000000); chk("col_f0_ones", col2, 5'b11111);
      goto(32); chk("wrap_row0", row2, 7'b0000001); chk("wrap_fs", fs2, 1'b1);
                chk("map0_row0", col2, 5'b00001);   chk("act_map0", act2, 1'b0);
      goto(36); chk("map0_row1", col2, 5'b00010);
      goto(44); chk("map0_row3", col2, 5'b01000);
                maps3[0 +: PIX] = {7{5'b10101}};
      goto(48); chk("tear_row4", col2, 5'b10000);
      goto(56); chk("tear_row6", col2, 5'b00010);
      goto(60); chk("new_map0", col2, 5'b10101); chk("new_fs", fs2, 1'b1);
      goto(62); sel3 = 2'd1;
      goto(88); chk("back_map1_act", act3, 2'd1); chk("back_map1_col", col3, 5'b11111);
      goto(90); sel3 = 2'd3;
      goto(116); chk("oor_act", act3, 2'd1); chk("oor_col", col3, 5'b11111); chk("oor_fs", fs3, 1'b1);
      goto(117); maps3 = '0; sel3 = 2'd0; cen = 1'b1; crow = 3'd2; ccol = 3'd4; ben = 1'b1;
      goto(152); chk("blink_f5_row", row2, 7'b0000100); chk("blink_f5", col2, 5'b00000);
      goto(180); chk("blink_f6", col2, 5'b00000);
      goto(208); chk("blink_f7", col2, 5'b10000);
      goto(236); chk("blink_f8", col2, 5'b10000);
      goto(264); chk("blink_f9", col2, 5'b00000);
      goto(265); ben = 1'b0;
      goto(292); chk("steady_cursor", col2, 5'b10000);
      goto(293); ccol = 3'd6; sel3 = 2'd1;
      goto(320); chk("cursor_col_oor", col2, 5'b00000); chk("act_before_rst", act2, 1'b1);
      goto(356); chk("row4_f12", row2, 7'b0010000);
      goto(357); rst = 1'b1;
      step();
      chk("mid_rst_row", row2, 7'b0);
      chk("mid_rst_col", col2, 5'b0);
      chk("mid_rst_act", act2, 1'b0);
      chk("mid_rst_act3", act3, 2'd0);
      rst = 1'b0; j = 0;
      repeat (3) begin
         step();
         chk("rst_blank_row", row2, 7'b0);
      end
      step();
      chk("rst_first_row", row2, 7'b0000001);
      chk("rst_first_fs", fs2, 1'b1);
      goto(40);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
